console_uart_bridge: RTL and testbench

Board-side endpoint for the Wrapper's console interface: consumes bytes the processor emits on CONSOLE_OUT (valid/ready) and serialises them onto a UART TX line, and deserialises bytes from a UART RX line into a small FIFO that drives CONSOLE_IN (valid/ack) back into the Wrapper. It sits between the top-level pins and the Wrapper and replaces the testbench-driven console handshakes on hardware.

---
 rtl/console_pkg.sv | 32 +++
 rtl/console_rx_fifo.sv | 46 ++++
 rtl/console_uart_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_console_uart_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared types and frame constants for the console UART bridge.
// Even parity is compiled in when CONSOLE_UART_PARITY_EN is defined.
package console_pkg;

  localparam int unsigned DataBits          = 8;
  localparam int unsigned FrameBitsNoParity = 10;
  localparam int unsigned FrameBitsParity   = 11;
  localparam int unsigned DefaultClksPerBit = 868;

`ifdef CONSOLE_UART_PARITY_EN
  localparam int unsigned FrameBits = FrameBitsParity;

  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData, TxParity, TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
  } rx_state_e;
`else
  localparam int unsigned FrameBits = FrameBitsNoParity;

  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData, TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxStop, RxWaitHigh
  } rx_state_e;
`endif

endpackage

// File: rtl/console_rx_fifo.sv
// Small byte FIFO between the UART receiver and CONSOLE_IN; head is read from the
// register array at the registered read pointer.
module console_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [PtrW:0]   count;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PtrW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/console_uart_bridge.sv
// UART endpoint for the Wrapper console: CONSOLE_OUT -> UART_TX, UART_RX -> FIFO -> CONSOLE_IN.
// Define CONSOLE_UART_PARITY_EN for an even parity bit in both directions.
module console_uart_bridge
  import console_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = DefaultClksPerBit,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       UART_RX,
  output logic       UART_TX,
  input  logic [7:0] CONSOLE_OUT,
  input  logic       CONSOLE_OUT_valid,
  output logic       CONSOLE_OUT_ready,
  output logic [7:0] CONSOLE_IN,
  output logic       CONSOLE_IN_valid,
  input  logic       CONSOLE_IN_ack,
  output logic       RX_OVERRUN,
  output logic       RX_FRAME_ERR
);

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LastBit = 3'(DataBits - 1);

  // ---------------- transmitter ----------------
  tx_state_e       tx_state, tx_state_nx;
  logic [CntW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]      tx_bit, tx_bit_nx;
  logic [7:0]      tx_byte, tx_byte_nx;
  logic            tx_line, tx_line_nx;
  logic            tx_ready, tx_ready_nx;

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + CntW'(1);
    tx_bit_nx   = tx_bit;
    tx_byte_nx  = tx_byte;
    tx_line_nx  = tx_line;
    case (tx_state)
      TxIdle: begin
        tx_cnt_nx  = '0;
        tx_line_nx = 1'b1;
        if (CONSOLE_OUT_valid) begin
          tx_state_nx = TxStart;
          tx_byte_nx  = CONSOLE_OUT;
          tx_line_nx  = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt == BitEnd) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = TxData;
          tx_line_nx  = tx_byte[0];
        end
      end
      TxData: begin
        if (tx_cnt == BitEnd) begin
          tx_cnt_nx = '0;
          if (tx_bit == LastBit) begin
`ifdef CONSOLE_UART_PARITY_EN
            tx_state_nx = TxParity;
            tx_line_nx  = ^tx_byte;
`else
            tx_state_nx = TxStop;
            tx_line_nx  = 1'b1;
`endif
          end else begin
            tx_bit_nx  = tx_bit + 3'd1;
            tx_line_nx = tx_byte[tx_bit + 3'd1];
          end
        end
      end
`ifdef CONSOLE_UART_PARITY_EN
      TxParity: begin
        if (tx_cnt == BitEnd) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TxStop;
          tx_line_nx  = 1'b1;
        end
      end
`endif
      TxStop: begin
        if (tx_cnt == BitEnd) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TxIdle;
        end
      end
      default: begin
        tx_state_nx = TxIdle;
        tx_line_nx  = 1'b1;
      end
    endcase
    tx_ready_nx = (tx_state_nx == TxIdle);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tx_state <= TxIdle;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= 8'h00;
      tx_line  <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_byte  <= tx_byte_nx;
      tx_line  <= tx_line_nx;
      tx_ready <= tx_ready_nx;
    end
  end

  assign UART_TX           = tx_line;
  assign CONSOLE_OUT_ready = tx_ready;

  // ---------------- receiver ----------------
  logic [1:0]      rx_sync;
  logic            rx_s;
  rx_state_e       rx_state, rx_state_nx;
  logic [CntW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]      rx_bit, rx_bit_nx;
  logic [7:0]      rx_data, rx_data_nx;
  logic            rx_push, frame_set, par_bad;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic            overrun, frame_err;

  assign rx_s = rx_sync[1];

`ifdef CONSOLE_UART_PARITY_EN
  logic rx_par_err, rx_par_err_nx;
  assign par_bad = rx_par_err;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + CntW'(1);
    rx_bit_nx   = rx_bit;
    rx_data_nx  = rx_data;
    rx_push     = 1'b0;
    frame_set   = 1'b0;
`ifdef CONSOLE_UART_PARITY_EN
    rx_par_err_nx = rx_par_err;
`endif
    case (rx_state)
      RxIdle: begin
        rx_cnt_nx = '0;
        if (!rx_s) rx_state_nx = RxStart;
      end
      RxStart: begin
        // Re-check at mid start bit so short glitches are rejected.
        if (rx_cnt == HalfEnd) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt == BitEnd) begin
          rx_cnt_nx  = '0;
          rx_data_nx = {rx_s, rx_data[7:1]};
          if (rx_bit == LastBit) begin
`ifdef CONSOLE_UART_PARITY_EN
            rx_state_nx = RxParity;
`else
            rx_state_nx = RxStop;
`endif
          end else begin
            rx_bit_nx = rx_bit + 3'd1;
          end
        end
      end
`ifdef CONSOLE_UART_PARITY_EN
      RxParity: begin
        if (rx_cnt == BitEnd) begin
          rx_cnt_nx     = '0;
          rx_par_err_nx = rx_s ^ (^rx_data);
          rx_state_nx   = RxStop;
        end
      end
`endif
      RxStop: begin
        if (rx_cnt == BitEnd) begin
          rx_cnt_nx = '0;
          if (!rx_s) begin
            frame_set   = 1'b1;
            rx_state_nx = RxWaitHigh;
          end else if (par_bad) begin
            frame_set   = 1'b1;
            rx_state_nx = RxIdle;
          end else begin
            rx_push     = 1'b1;
            rx_state_nx = RxIdle;
          end
        end
      end
      RxWaitHigh: begin
        rx_cnt_nx = '0;
        if (rx_s) rx_state_nx = RxIdle;
      end
      default: rx_state_nx = RxIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_sync   <= 2'b11;
      rx_state  <= RxIdle;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_data   <= 8'h00;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef CONSOLE_UART_PARITY_EN
      rx_par_err <= 1'b0;
`endif
    end else begin
      rx_sync   <= {rx_sync[0], UART_RX};
      rx_state  <= rx_state_nx;
      rx_cnt    <= rx_cnt_nx;
      rx_bit    <= rx_bit_nx;
      rx_data   <= rx_data_nx;
      overrun   <= overrun | (rx_push && fifo_full && !fifo_pop);
      frame_err <= frame_err | frame_set;
`ifdef CONSOLE_UART_PARITY_EN
      rx_par_err <= rx_par_err_nx;
`endif
    end
  end

  assign fifo_pop = CONSOLE_IN_ack && !fifo_empty;

  console_rx_fifo #(
    .DEPTH(RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (CLK),
    .rst_n    (RESETn),
    .push     (rx_push),
    .push_data(rx_data),
    .pop      (fifo_pop),
    .head     (CONSOLE_IN),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign CONSOLE_IN_valid = !fifo_empty;
  assign RX_OVERRUN       = overrun;
  assign RX_FRAME_ERR     = frame_err;

endmodule

// File: tb/tb_console_uart_bridge.sv
// Self-checking bench for console_uart_bridge at CLKS_PER_BIT = 16, RX_FIFO_DEPTH = 4.
module tb_console_uart_bridge;
  import console_pkg::*;

  localparam int Cpb = 16;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       UART_RX;
  logic       UART_TX;
  logic [7:0] CONSOLE_OUT;
  logic       CONSOLE_OUT_valid;
  logic       CONSOLE_OUT_ready;
  logic [7:0] CONSOLE_IN;
  logic       CONSOLE_IN_valid;
  logic       CONSOLE_IN_ack;
  logic       RX_OVERRUN;
  logic       RX_FRAME_ERR;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_accept;
  } rx_vec_t;

  tx_vec_t tx_tab[5];
  rx_vec_t rx_tab[4];

  console_uart_bridge #(
    .CLKS_PER_BIT (Cpb),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .CLK              (CLK),
    .RESETn           (RESETn),
    .UART_RX          (UART_RX),
    .UART_TX          (UART_TX),
    .CONSOLE_OUT      (CONSOLE_OUT),
    .CONSOLE_OUT_valid(CONSOLE_OUT_valid),
    .CONSOLE_OUT_ready(CONSOLE_OUT_ready),
    .CONSOLE_IN       (CONSOLE_IN),
    .CONSOLE_IN_valid (CONSOLE_IN_valid),
    .CONSOLE_IN_ack   (CONSOLE_IN_ack),
    .RX_OVERRUN       (RX_OVERRUN),
    .RX_FRAME_ERR     (RX_FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!CONSOLE_OUT_ready && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("tx_ready_wait", 32'(CONSOLE_OUT_ready), 1);
  endtask

  task automatic send_tx(input logic [7:0] d, input logic p);
    logic [FrameBits-1:0] got, exp;
    int lowc;
    wait_ready();
    CONSOLE_OUT       = d;
    CONSOLE_OUT_valid = 1'b1;
    @(posedge CLK);
    #1;
    CONSOLE_OUT_valid = 1'b0;
    CONSOLE_OUT       = 8'($urandom);
    lowc = 0;
    got  = '0;
    for (int c = 0; c < int'(FrameBits) * Cpb; c++) begin
      @(negedge CLK);
      if (!CONSOLE_OUT_ready) lowc++;
      if (c % Cpb == Cpb / 2) got[c / Cpb] = UART_TX;
    end
    @(negedge CLK);
    check("tx_ready_back", 32'(CONSOLE_OUT_ready), 1);
`ifdef CONSOLE_UART_PARITY_EN
    exp = {1'b1, p, d, 1'b0};
`else
    exp = {1'b1, d, 1'b0};
`endif
    check($sformatf("tx_frame_%02h", d), 32'(got), 32'(exp));
    check("tx_ready_low_cycles", lowc, int'(FrameBits) * Cpb);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop, input logic par);
    UART_RX = 1'b0;
    repeat (Cpb) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      repeat (Cpb) @(negedge CLK);
    end
`ifdef CONSOLE_UART_PARITY_EN
    UART_RX = par;
    repeat (Cpb) @(negedge CLK);
`endif
    UART_RX = stop;
    repeat (Cpb) @(negedge CLK);
    UART_RX = 1'b1;
  endtask

  task automatic pop_expect();
    int n = 0;
    logic [7:0] e;
    while (!CONSOLE_IN_valid && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("rx_valid", 32'(CONSOLE_IN_valid), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check("rx_data", 32'(CONSOLE_IN), 32'(e));
    repeat (2) @(negedge CLK);
    check("rx_data_stable", 32'(CONSOLE_IN), 32'(e));
    CONSOLE_IN_ack = 1'b1;
    @(negedge CLK);
    CONSOLE_IN_ack = 1'b0;
    if (exp_q.size() == 0) check("rx_valid_fall", 32'(CONSOLE_IN_valid), 0);
  endtask

  initial begin
    tx_tab[0] = '{8'h41, 1'b0};
    tx_tab[1] = '{8'hA5, 1'b0};
    tx_tab[2] = '{8'h00, 1'b0};
    tx_tab[3] = '{8'h80, 1'b1};
    tx_tab[4] = '{8'h03, 1'b0};
    rx_tab[0] = '{8'h5A, 1'b1, 1'b1};
    rx_tab[1] = '{8'h00, 1'b1, 1'b1};
    rx_tab[2] = '{8'hFF, 1'b1, 1'b1};
    rx_tab[3] = '{8'h81, 1'b1, 1'b1};

    RESETn            = 1'b0;
    UART_RX           = 1'b1;
    CONSOLE_OUT       = 8'h00;
    CONSOLE_OUT_valid = 1'b0;
    CONSOLE_IN_ack    = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", 32'(UART_TX), 1);
    check("rst_ready", 32'(CONSOLE_OUT_ready), 1);
    check("rst_in", 32'(CONSOLE_IN), 0);
    check("rst_in_valid", 32'(CONSOLE_IN_valid), 0);
    check("rst_overrun", 32'(RX_OVERRUN), 0);
    check("rst_frame_err", 32'(RX_FRAME_ERR), 0);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 5; i++) send_tx(tx_tab[i].data, tx_tab[i].exp_par);

    for (int i = 0; i < 4; i++) begin
      drive_rx(rx_tab[i].data, rx_tab[i].stop, ^rx_tab[i].data);
      if (rx_tab[i].exp_accept) exp_q.push_back(rx_tab[i].data);
      pop_expect();
    end

    // Short low glitch plus an ack with nothing buffered.
    UART_RX = 1'b0;
    repeat (4) @(negedge CLK);
    UART_RX        = 1'b1;
    CONSOLE_IN_ack = 1'b1;
    @(negedge CLK);
    CONSOLE_IN_ack = 1'b0;
    repeat (40) @(negedge CLK);
    check("glitch_valid", 32'(CONSOLE_IN_valid), 0);
    check("glitch_frame_err", 32'(RX_FRAME_ERR), 0);
    check("glitch_overrun", 32'(RX_OVERRUN), 0);
    drive_rx(8'h96, 1'b1, ^8'h96);
    exp_q.push_back(8'h96);
    pop_expect();

    // Five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      drive_rx(8'(i), 1'b1, ^8'(i));
      if (exp_q.size() < 4) exp_q.push_back(8'(i));
      if (i == 4) check("overrun_not_yet", 32'(RX_OVERRUN), 0);
    end
    repeat (4) @(negedge CLK);
    check("overrun_set", 32'(RX_OVERRUN), 1);
    for (int i = 0; i < 4; i++) pop_expect();

    drive_rx(8'h33, 1'b0, ^8'h33);
    repeat (20) @(negedge CLK);
    check("stop0_no_byte", 32'(CONSOLE_IN_valid), 0);
    check("stop0_frame_err", 32'(RX_FRAME_ERR), 1);

    // Reset during the start bit of 0xFF.
    wait_ready();
    CONSOLE_OUT       = 8'hFF;
    CONSOLE_OUT_valid = 1'b1;
    @(posedge CLK);
    #1;
    CONSOLE_OUT_valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("midtx_start_bit", 32'(UART_TX), 0);
    #2;
    RESETn = 1'b0;
    #1;
    check("midtx_tx_async", 32'(UART_TX), 1);
    check("midtx_ready_rst", 32'(CONSOLE_OUT_ready), 1);
    @(negedge CLK);
    check("midtx_overrun_clr", 32'(RX_OVERRUN), 0);
    check("midtx_frame_err_clr", 32'(RX_FRAME_ERR), 0);
    RESETn = 1'b1;
    @(negedge CLK);
    check("midtx_ready_after", 32'(CONSOLE_OUT_ready), 1);
    send_tx(8'h41, 1'b0);

`ifdef CONSOLE_UART_PARITY_EN
    drive_rx(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge CLK);
    check("par_bad_no_byte", 32'(CONSOLE_IN_valid), 0);
    check("par_bad_frame_err", 32'(RX_FRAME_ERR), 1);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
